// File: rtl/m_if_fetch.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem read, prefetch FIFO
// of {ir, pc} entries presented to ID over valid/ready; redirects flush and refetch.
module m_if_fetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic        w_imem_req,
  output logic [31:0] w_imem_adr,
  input  logic [31:0] w_imem_rdata,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_id_valid,
  input  logic        w_id_ready,
  output logic [31:0] w_id_ir,
  output logic [31:0] w_id_pc,
  output logic [31:0] w_id_npc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_fpc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   fifo_ir [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [AW+1:0] occupancy;
  logic [31:0]   redirect_adr;

  always_comb begin
    redirect_adr = w_redirect_pc & 32'hFFFF_FFFC;
    w_id_valid   = !w_rst && (r_count != '0);
    pop          = w_id_valid && w_id_ready;
    // Slots already committed (buffered + in flight) minus the one leaving this cycle.
    occupancy    = (AW+2)'(r_count) + (AW+2)'(r_inflight) - (AW+2)'(pop);
    issue        = !w_rst && (w_redirect || (occupancy < (AW+2)'(DEPTH)));
    push         = r_inflight && !w_redirect;
    w_imem_req   = issue;
    w_imem_adr   = '0;
    if (!w_rst) begin
      w_imem_adr = w_redirect ? redirect_adr : r_fpc;
    end
    w_id_ir  = '0;
    w_id_pc  = '0;
    w_id_npc = '0;
    if (w_id_valid) begin
      w_id_ir  = fifo_ir[r_rd_ptr];
      w_id_pc  = fifo_pc[r_rd_ptr];
      w_id_npc = fifo_pc[r_rd_ptr] + 32'd4;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_fpc         <= RESET_PC & 32'hFFFF_FFFC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (w_redirect) begin
      // Flush drops any response landing this cycle; the target read is tagged here.
      r_fpc         <= redirect_adr + 32'd4;
      r_inflight    <= 1'b1;
      r_inflight_pc <= redirect_adr;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_inflight <= issue;
      if (issue) begin
        r_fpc         <= r_fpc + 32'd4;
        r_inflight_pc <= r_fpc;
      end
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst && push) begin
      fifo_ir[r_wr_ptr] <= w_imem_rdata;
      fifo_pc[r_wr_ptr] <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_m_if_fetch.sv
// Self-checking bench for m_if_fetch: directed scenarios plus a randomized run
// against a stream-level model (expected next PC, fetch address, occupancy).
module tb_m_if_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_adr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic [31:0] id_npc;

  int checks   = 0;
  int failures = 0;

  m_if_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .w_clk        (clk),
    .w_rst        (rst),
    .w_imem_req   (imem_req),
    .w_imem_adr   (imem_adr),
    .w_imem_rdata (imem_rdata),
    .w_redirect   (redirect),
    .w_redirect_pc(redirect_pc),
    .w_id_valid   (id_valid),
    .w_id_ready   (id_ready),
    .w_id_ir      (id_ir),
    .w_id_pc      (id_pc),
    .w_id_npc     (id_npc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  // Synchronous-read memory; garbage when no read was issued.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? imem_word(imem_adr) : 32'hDEAD_BEEF;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
    #1;
    checks++;
    if ({imem_req, id_valid, id_ir, id_pc, id_npc} !== '0) begin
      failures++;
      $display("FAIL reset_pre got req=%b v=%b ir=%h pc=%h npc=%h exp all 0", imem_req, id_valid, id_ir, id_pc, id_npc);
    end
    tick;
    redirect = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_adr, id_valid, id_ir, id_pc, id_npc} !== '0) begin
      failures++;
      $display("FAIL reset_hold got req=%b adr=%h v=%b ir=%h pc=%h exp all 0", imem_req, imem_adr, id_valid, id_ir, id_pc);
    end
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_adr, id_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got req=%b adr=%h v=%b exp req=1 adr=%h v=0", imem_req, imem_adr, id_valid, RESET_PC);
    end
  endtask

  task automatic test_cold_start;
    logic [31:0] e;
    do_reset;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({imem_req, imem_adr} !== {1'b1, 32'(4 * c)}) begin
        failures++;
        $display("FAIL cold_req c=%0d got req=%b adr=%h exp req=1 adr=%h", c, imem_req, imem_adr, 32'(4 * c));
      end
      e = (c < 2) ? 32'h0 : 32'(4 * (c - 2));
      checks++;
      if (c < 2) begin
        if (id_valid !== 1'b0) begin
          failures++;
          $display("FAIL cold_valid_early c=%0d got v=%b exp 0", c, id_valid);
        end
      end else if ({id_valid, id_pc, id_ir, id_npc} !== {1'b1, e, imem_word(e), e + 32'd4}) begin
        failures++;
        $display("FAIL cold_head c=%0d got v=%b pc=%h ir=%h npc=%h exp pc=%h", c, id_valid, id_pc, id_ir, id_npc, e);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    do_reset;
    tick; tick;
    id_ready = 1'b0;
    for (int c = 2; c < 8; c++) begin
      #1;
      checks++;
      if ({id_valid, id_pc, id_ir} !== {1'b1, 32'h0, 32'd100}) begin
        failures++;
        $display("FAIL bp_hold_head c=%0d got v=%b pc=%h ir=%h exp v=1 pc=0 ir=100", c, id_valid, id_pc, id_ir);
      end
      checks++;
      if (c < 4) begin
        if ({imem_req, imem_adr} !== {1'b1, 32'(4 * c)}) begin
          failures++;
          $display("FAIL bp_fill_req c=%0d got req=%b adr=%h exp req=1 adr=%h", c, imem_req, imem_adr, 32'(4 * c));
        end
      end else if (imem_req !== 1'b0) begin
        failures++;
        $display("FAIL bp_full_req c=%0d got req=%b exp 0", c, imem_req);
      end
      tick;
    end
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      e = 32'(4 * k);
      checks++;
      if ({id_valid, id_pc, id_ir, id_npc} !== {1'b1, e, imem_word(e), e + 32'd4}) begin
        failures++;
        $display("FAIL bp_resume k=%0d got v=%b pc=%h ir=%h exp pc=%h", k, id_valid, id_pc, id_ir, e);
      end
      if (k == 0) begin
        checks++;
        if ({imem_req, imem_adr} !== {1'b1, 32'h10}) begin
          failures++;
          $display("FAIL bp_req_on_pop got req=%b adr=%h exp req=1 adr=00000010", imem_req, imem_adr);
        end
      end
      tick;
    end
  endtask

  task automatic test_redirect;
    logic [31:0] e;
    do_reset;
    for (int c = 0; c < 6; c++) tick;
    id_ready = 1'b0;
    #1;
    checks++;
    if ({id_valid, id_pc} !== {1'b1, 32'h10}) begin
      failures++;
      $display("FAIL redir_setup got v=%b pc=%h exp v=1 pc=00000010", id_valid, id_pc);
    end
    tick;
    redirect = 1'b1; redirect_pc = 32'h8;
    #1;
    checks++;
    if ({imem_req, imem_adr} !== {1'b1, 32'h8}) begin
      failures++;
      $display("FAIL redir_req got req=%b adr=%h exp req=1 adr=00000008", imem_req, imem_adr);
    end
    tick;
    redirect = 1'b0; id_ready = 1'b1;
    #1;
    checks++;
    if ({id_valid, imem_req, imem_adr} !== {1'b0, 1'b1, 32'hC}) begin
      failures++;
      $display("FAIL redir_gap got v=%b req=%b adr=%h exp v=0 req=1 adr=0000000c", id_valid, imem_req, imem_adr);
    end
    tick;
    for (int k = 0; k < 6; k++) begin
      #1;
      e = 32'h8 + 32'(4 * k);
      checks++;
      if ({id_valid, id_pc, id_ir, id_npc} !== {1'b1, e, imem_word(e), e + 32'd4}) begin
        failures++;
        $display("FAIL redir_stream k=%0d got v=%b pc=%h ir=%h exp pc=%h", k, id_valid, id_pc, id_ir, e);
      end
      tick;
    end
  endtask

  task automatic test_redirect_pop;
    logic [31:0] e;
    do_reset;
    tick; tick; tick;
    redirect = 1'b1; redirect_pc = 32'h43;
    #1;
    checks++;
    if ({id_valid, id_pc, imem_req, imem_adr} !== {1'b1, 32'h4, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL rpop_cycle got v=%b pc=%h req=%b adr=%h exp v=1 pc=4 req=1 adr=40", id_valid, id_pc, imem_req, imem_adr);
    end
    tick;
    redirect = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("FAIL rpop_gap got v=%b exp 0", id_valid);
    end
    tick;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = 32'h40 + 32'(4 * k);
      checks++;
      if ({id_valid, id_pc, id_ir} !== {1'b1, e, imem_word(e)}) begin
        failures++;
        $display("FAIL rpop_stream k=%0d got v=%b pc=%h ir=%h exp pc=%h", k, id_valid, id_pc, id_ir, e);
      end
      tick;
    end
  endtask

  task automatic test_wrap;
    do_reset;
    tick; tick;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({imem_req, imem_adr} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL wrap_adr got req=%b adr=%h exp req=1 adr=fffffffc", imem_req, imem_adr);
    end
    tick;
    redirect = 1'b0;
    #1;
    checks++;
    if ({id_valid, imem_req, imem_adr} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wrap_next_adr got v=%b req=%b adr=%h exp v=0 req=1 adr=0", id_valid, imem_req, imem_adr);
    end
    tick;
    #1;
    checks++;
    if ({id_valid, id_pc, id_ir, id_npc} !== {1'b1, 32'hFFFF_FFFC, 32'h4000_0063, 32'h0}) begin
      failures++;
      $display("FAIL wrap_head got v=%b pc=%h ir=%h npc=%h exp pc=fffffffc ir=40000063 npc=0", id_valid, id_pc, id_ir, id_npc);
    end
    tick;
    #1;
    checks++;
    if ({id_valid, id_pc, id_ir, id_npc} !== {1'b1, 32'h0, 32'd100, 32'h4}) begin
      failures++;
      $display("FAIL wrap_after got v=%b pc=%h ir=%h npc=%h exp pc=0 ir=100 npc=4", id_valid, id_pc, id_ir, id_npc);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    tick; tick;
    id_ready = 1'b0;
    tick; tick;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_adr, id_valid, id_ir, id_pc, id_npc} !== '0) begin
      failures++;
      $display("FAIL rmid_outputs got req=%b adr=%h v=%b ir=%h pc=%h exp all 0", imem_req, imem_adr, id_valid, id_ir, id_pc);
    end
    tick;
    rst = 1'b0; id_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (c < 2) begin
        if ({id_valid, imem_req, imem_adr} !== {1'b0, 1'b1, RESET_PC + 32'(4 * c)}) begin
          failures++;
          $display("FAIL rmid_restart c=%0d got v=%b req=%b adr=%h exp v=0 req=1", c, id_valid, imem_req, imem_adr);
        end
      end else if ({id_valid, id_pc, id_ir} !== {1'b1, RESET_PC + 32'(4 * (c - 2)), imem_word(RESET_PC + 32'(4 * (c - 2)))}) begin
        failures++;
        $display("FAIL rmid_head c=%0d got v=%b pc=%h ir=%h", c, id_valid, id_pc, id_ir);
      end
      tick;
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, exp_fadr, tgt;
    int          n_out, infl;
    logic        vexp, pop, reqexp;
    do_reset;
    exp_pc = RESET_PC; exp_fadr = RESET_PC; n_out = 0; infl = 0;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(99) == 0);
      redirect    = ($urandom_range(15) == 0);
      redirect_pc = $urandom;
      id_ready    = ($urandom_range(3) != 0);
      #1;
      if (rst) begin
        checks++;
        if ({imem_req, id_valid, id_ir, id_pc, id_npc} !== '0) begin
          failures++;
          $display("FAIL rnd_reset c=%0d got req=%b v=%b pc=%h", c, imem_req, id_valid, id_pc);
        end
        exp_pc = RESET_PC; exp_fadr = RESET_PC; n_out = 0; infl = 0;
      end else begin
        vexp = (n_out - infl) > 0;
        checks++;
        if (id_valid !== vexp) begin
          failures++;
          $display("FAIL rnd_valid c=%0d got %b exp %b", c, id_valid, vexp);
        end else if (vexp) begin
          checks++;
          if ({id_pc, id_ir, id_npc} !== {exp_pc, imem_word(exp_pc), exp_pc + 32'd4}) begin
            failures++;
            $display("FAIL rnd_head c=%0d got pc=%h ir=%h npc=%h exp pc=%h", c, id_pc, id_ir, id_npc, exp_pc);
          end
        end
        pop = vexp && id_ready;
        if (redirect) begin
          tgt = {redirect_pc[31:2], 2'b00};
          checks++;
          if ({imem_req, imem_adr} !== {1'b1, tgt}) begin
            failures++;
            $display("FAIL rnd_redir c=%0d got req=%b adr=%h exp adr=%h", c, imem_req, imem_adr, tgt);
          end
          exp_pc = tgt; exp_fadr = tgt + 32'd4; n_out = 1; infl = 1;
        end else begin
          reqexp = (n_out - int'(pop)) < int'(DEPTH);
          checks++;
          if (imem_req !== reqexp || (reqexp && imem_adr !== exp_fadr)) begin
            failures++;
            $display("FAIL rnd_req c=%0d got req=%b adr=%h exp req=%b adr=%h", c, imem_req, imem_adr, reqexp, exp_fadr);
          end
          if (pop) exp_pc = exp_pc + 32'd4;
          if (reqexp) exp_fadr = exp_fadr + 32'd4;
          n_out = n_out - int'(pop) + int'(reqexp);
          infl  = int'(reqexp);
        end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_cold_start;
    test_backpressure;
    test_redirect;
    test_redirect_pop;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
